// File: rtl/slowram_shadow_ctl_pkg.sv
// Shared types and constants for the slow RAM (E0/E1) port A sequencer.
package slowram_shadow_ctl_pkg;

  // Shadow register bit positions; a 0 bit enables shadowing of that region.
  localparam int SH_TEXT  = 0;
  localparam int SH_HGR1  = 1;
  localparam int SH_HGR2  = 2;
  localparam int SH_SHR   = 3;
  localparam int SH_BANK1 = 4;
  localparam int SH_ALT   = 5;

  localparam logic [15:0] TEXT_LO = 16'h0400;
  localparam logic [15:0] TEXT_HI = 16'h07FF;
  localparam logic [15:0] ALT_LO  = 16'h0800;
  localparam logic [15:0] ALT_HI  = 16'h0BFF;
  localparam logic [15:0] HGR1_LO = 16'h2000;
  localparam logic [15:0] HGR1_HI = 16'h3FFF;
  localparam logic [15:0] HGR2_LO = 16'h4000;
  localparam logic [15:0] HGR2_HI = 16'h5FFF;

  typedef struct packed {
    logic        bnk;
    logic [15:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_Q,
    ST_WAIT_D,
    ST_ISSUE,
    ST_CAPT
  } state_t;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/slowram_shadow_ctl_shadow_fifo.sv
// Synchronous FIFO holding shadow write-throughs; push while full is accepted
// only when a pop happens in the same cycle.
module shadow_fifo
  import slowram_shadow_ctl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  fifo_entry_t din_i,
  input  logic        pop_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/slowram_shadow_ctl.sv
// Slow RAM port A sequencer: queues shadow write-throughs from banks 00/01 and
// serialises direct E0/E1 CPU accesses onto 1 MHz slots, stalling the CPU.
module slowram_shadow_ctl
  import slowram_shadow_ctl_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SLOW_DIV = 14
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  shadow,
  input  logic        io,
  output logic        cpu_stall,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        slow_ce,
  output logic        slow_we,
  output logic [16:0] slow_addr,
  output logic [7:0]  slow_din,
  input  logic [7:0]  slow_dout
);
  localparam int CW = $clog2(SLOW_DIV);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  fifo_entry_t   pend_q, pend_d, cur, push_data, head;
  logic          pend_we_q, pend_we_d;
  logic          tick, push, pop, full, empty;
  logic          bank00, bank01, b1_ok, hgr, sh_region, sh_hit, direct;
  logic          slow_ce_q, slow_we_q, rd_valid_q;
  logic [16:0]   slow_addr_q;
  logic [7:0]    slow_din_q, rd_data_q;

  assign tick = (cnt_q == CW'(SLOW_DIV - 1));
  assign pop  = tick & ~empty;

  // Bank 01 text/alt/HGR need bit4 clear too; the SHR term covers bank 01 only.
  assign bank00 = (cpu_bank == 8'h00);
  assign bank01 = (cpu_bank == 8'h01);
  assign b1_ok  = bank00 | ~shadow[SH_BANK1];
  assign hgr    = in_range(cpu_addr, HGR1_LO, HGR2_HI);
  assign sh_region =
      (~shadow[SH_TEXT] & b1_ok & in_range(cpu_addr, TEXT_LO, TEXT_HI)) |
      (~shadow[SH_ALT]  & b1_ok & in_range(cpu_addr, ALT_LO, ALT_HI))   |
      (~shadow[SH_HGR1] & b1_ok & in_range(cpu_addr, HGR1_LO, HGR1_HI)) |
      (~shadow[SH_HGR2] & b1_ok & in_range(cpu_addr, HGR2_LO, HGR2_HI)) |
      (~shadow[SH_SHR]  & bank01 & hgr);
  assign sh_hit = cpu_req & cpu_we & ~io & (bank00 | bank01) & sh_region;
  assign direct = cpu_req & ~io & ((cpu_bank == 8'hE0) | (cpu_bank == 8'hE1));
  assign cur    = '{bnk: cpu_bank[0], addr: cpu_addr, data: cpu_dout};

  shadow_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_n_i (reset_n),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    push      = 1'b0;
    push_data = cur;
    cpu_stall = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (direct) begin
          pend_d    = cur;
          pend_we_d = cpu_we;
          state_d   = ST_WAIT_D;
          cpu_stall = 1'b1;
        end else if (sh_hit) begin
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            pend_d    = cur;
            state_d   = ST_WAIT_Q;
            cpu_stall = 1'b1;
          end
        end
      end
      ST_WAIT_Q: begin
        if (!full || pop) begin
          push      = 1'b1;
          push_data = pend_q;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_D: if (tick && empty) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = pend_we_q ? ST_IDLE : ST_CAPT;
      ST_CAPT:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      cnt_q     <= tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Queued writes win the slot, so a waiting direct access only goes once drained.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      slow_ce_q   <= 1'b0;
      slow_we_q   <= 1'b0;
      slow_addr_q <= '0;
      slow_din_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      slow_ce_q  <= 1'b0;
      slow_we_q  <= 1'b0;
      rd_valid_q <= (state_q == ST_CAPT);
      if (pop) begin
        slow_ce_q   <= 1'b1;
        slow_we_q   <= 1'b1;
        slow_addr_q <= {head.bnk, head.addr};
        slow_din_q  <= head.data;
      end else if (state_q == ST_WAIT_D && tick) begin
        slow_ce_q   <= 1'b1;
        slow_we_q   <= pend_we_q;
        slow_addr_q <= {pend_q.bnk, pend_q.addr};
        slow_din_q  <= pend_q.data;
      end
      if (state_q == ST_CAPT) rd_data_q <= slow_dout;
    end
  end

  assign slow_ce   = slow_ce_q;
  assign slow_we   = slow_we_q;
  assign slow_addr = slow_addr_q;
  assign slow_din  = slow_din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_slowram_shadow_ctl.sv
// Directed bench for slowram_shadow_ctl with a small slow RAM behind port A.
module tb_slowram_shadow_ctl;
  localparam int DEPTH    = 4;
  localparam int SLOW_DIV = 14;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, io = 1'b0;
  logic [7:0]  cpu_bank = '0, cpu_dout = '0, shadow = 8'hFF;
  logic [15:0] cpu_addr = '0;
  logic        cpu_stall, rd_valid, slow_ce, slow_we;
  logic [7:0]  rd_data, slow_din;
  logic [7:0]  slow_dout = '0;
  logic [16:0] slow_addr;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rdv_cnt = 0;
  logic [7:0] rdv_data  = '0;
  logic       rdv_stall = 1'b0;

  logic [16:0] ce_addr [$];
  logic [7:0]  ce_din  [$];
  logic        ce_we   [$];
  int          ce_cyc  [$];
  logic [7:0]  mem [0:131071];

  slowram_shadow_ctl #(.DEPTH(DEPTH), .SLOW_DIV(SLOW_DIV)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_bank(cpu_bank), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .shadow(shadow),
    .io(io), .cpu_stall(cpu_stall), .rd_valid(rd_valid), .rd_data(rd_data),
    .slow_ce(slow_ce), .slow_we(slow_we), .slow_addr(slow_addr), .slow_din(slow_din),
    .slow_dout(slow_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (slow_ce && slow_we)  mem[slow_addr] <= slow_din;
    if (slow_ce && !slow_we) slow_dout <= mem[slow_addr];
  end

  always @(negedge clk_sys) begin
    if (slow_ce) begin
      ce_addr.push_back(slow_addr);
      ce_din.push_back(slow_din);
      ce_we.push_back(slow_we);
      ce_cyc.push_back(cyc);
    end
    if (rd_valid) begin
      rdv_cnt   <= rdv_cnt + 1;
      rdv_data  <= rd_data;
      rdv_stall <= cpu_stall;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // One CPU bus cycle starting just after a rising edge; returns stall seen mid-cycle.
  task automatic bus(input logic we, input logic [7:0] bank, input logic [15:0] addr,
                     input logic [7:0] data, input logic io_v, output logic st);
    cpu_we = we; cpu_bank = bank; cpu_addr = addr; cpu_dout = data; io = io_v;
    cpu_req = 1'b1;
    @(negedge clk_sys);
    st = cpu_stall;
    @(posedge clk_sys);
    #1;
    cpu_req = 1'b0; io = 1'b0;
  endtask

  task automatic wait_unstall(input int maxc);
    int n = 0;
    @(negedge clk_sys);
    while (cpu_stall && n < maxc) begin
      @(negedge clk_sys);
      n++;
    end
    vectors++;
    if (cpu_stall) begin
      errors++;
      $display("FAIL stall_timeout: cpu_stall=%b after %0d cycles, required 0", cpu_stall, n);
    end
    @(posedge clk_sys);
    #1;
  endtask

  // Leaves the bench at the start of slot counter value 1 (just after a slow write).
  task automatic sync_slot();
    logic st;
    int n = 0;
    shadow = 8'h00;
    bus(1'b1, 8'h00, 16'h0500, 8'h00, 1'b0, st);
    @(negedge clk_sys);
    while (!slow_ce && n < 3 * SLOW_DIV) begin
      @(negedge clk_sys);
      n++;
    end
    vectors++;
    if (!slow_ce) begin
      errors++;
      $display("FAIL sync_slot: no slow_ce within %0d cycles", n);
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if ({cpu_stall, rd_valid, rd_data, slow_ce, slow_we, slow_addr, slow_din} !== '0) begin
      errors++;
      $display("FAIL %s: stall=%b rdv=%b rdd=%h ce=%b we=%b addr=%h din=%h, required all 0",
               tag, cpu_stall, rd_valid, rd_data, slow_ce, slow_we, slow_addr, slow_din);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    @(negedge clk_sys);
    check_zero("reset_held");
    reset_n = 1'b1;
    step(2);
    @(negedge clk_sys);
    check_zero("reset_released");
    step(1);
  endtask

  task automatic test_text();
    logic st;
    int b = ce_addr.size();
    shadow = 8'h00;
    bus(1'b1, 8'h00, 16'h0400, 8'hAA, 1'b0, st);
    vectors++;
    if (st !== 1'b0) begin errors++; $display("FAIL text_stall: got %b, required 0", st); end
    step(SLOW_DIV + 2);
    vectors++;
    if (ce_addr.size() - b != 1) begin
      errors++;
      $display("FAIL text_count: got %0d slow accesses, required 1", ce_addr.size() - b);
    end else begin
      vectors++;
      if (ce_addr[b] !== 17'h00400 || ce_din[b] !== 8'hAA || ce_we[b] !== 1'b1) begin
        errors++;
        $display("FAIL text_write: addr=%h din=%h we=%b, required 00400 AA 1",
                 ce_addr[b], ce_din[b], ce_we[b]);
      end
    end
  endtask

  task automatic test_shr();
    logic st;
    int b = ce_addr.size();
    shadow = 8'h08;
    bus(1'b1, 8'h01, 16'h2000, 8'h55, 1'b0, st);
    step(SLOW_DIV + 2);
    vectors++;
    if (ce_addr.size() - b != 1) begin
      errors++;
      $display("FAIL bank1_hgr_count: got %0d, required 1", ce_addr.size() - b);
    end else begin
      vectors++;
      if (ce_addr[b] !== 17'h12000 || ce_din[b] !== 8'h55 || ce_we[b] !== 1'b1) begin
        errors++;
        $display("FAIL bank1_hgr_write: addr=%h din=%h we=%b, required 12000 55 1",
                 ce_addr[b], ce_din[b], ce_we[b]);
      end
    end
    b = ce_addr.size();
    shadow = 8'h18;
    bus(1'b1, 8'h01, 16'h2000, 8'h66, 1'b0, st);
    step(2 * SLOW_DIV);
    vectors++;
    if (ce_addr.size() != b) begin
      errors++;
      $display("FAIL bank1_inhibit: got %0d slow accesses, required 0", ce_addr.size() - b);
    end
  endtask

  task automatic test_back_to_back();
    logic st [5];
    int b;
    sync_slot();
    b = ce_addr.size();
    for (int i = 0; i < 5; i++)
      bus(1'b1, 8'h00, 16'h0400 + 16'(i), 8'h10 + 8'(i), 1'b0, st[i]);
    vectors++;
    if ({st[0], st[1], st[2], st[3], st[4]} !== 5'b00001) begin
      errors++;
      $display("FAIL b2b_stall: stalls=%b%b%b%b%b, required 00001",
               st[0], st[1], st[2], st[3], st[4]);
    end
    wait_unstall(2 * SLOW_DIV);
    step(6 * SLOW_DIV);
    vectors++;
    if (ce_addr.size() - b != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d slow writes, required 5", ce_addr.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (ce_addr[b+i] !== 17'h00400 + 17'(i) || ce_din[b+i] !== 8'h10 + 8'(i) ||
            (i > 0 && ce_cyc[b+i] - ce_cyc[b+i-1] != SLOW_DIV)) begin
          errors++;
          $display("FAIL b2b_entry%0d: addr=%h din=%h gap=%0d, required %h %h %0d", i,
                   ce_addr[b+i], ce_din[b+i], (i > 0) ? ce_cyc[b+i] - ce_cyc[b+i-1] : SLOW_DIV,
                   17'h00400 + 17'(i), 8'h10 + 8'(i), SLOW_DIV);
        end
      end
    end
  endtask

  task automatic test_read();
    logic s0, s1, s2;
    int b, r;
    sync_slot();
    b = ce_addr.size();
    r = rdv_cnt;
    bus(1'b1, 8'h00, 16'h0400, 8'h5A, 1'b0, s0);
    bus(1'b1, 8'h00, 16'h0400, 8'hC3, 1'b0, s1);
    bus(1'b0, 8'hE0, 16'h0400, 8'h00, 1'b0, s2);
    vectors++;
    if ({s0, s1, s2} !== 3'b001) begin
      errors++;
      $display("FAIL read_req_stall: stalls=%b%b%b, required 001", s0, s1, s2);
    end
    wait_unstall(4 * SLOW_DIV);
    step(3);
    vectors++;
    if (ce_addr.size() - b != 3) begin
      errors++;
      $display("FAIL read_count: got %0d slow accesses, required 3", ce_addr.size() - b);
    end else begin
      vectors++;
      if (ce_din[b] !== 8'h5A || ce_din[b+1] !== 8'hC3 || ce_we[b+1] !== 1'b1 ||
          ce_addr[b+2] !== 17'h00400 || ce_we[b+2] !== 1'b0 ||
          ce_cyc[b+2] - ce_cyc[b] != 2 * SLOW_DIV) begin
        errors++;
        $display("FAIL read_order: din0=%h din1=%h rd_addr=%h rd_we=%b span=%0d, required 5A C3 00400 0 %0d",
                 ce_din[b], ce_din[b+1], ce_addr[b+2], ce_we[b+2], ce_cyc[b+2] - ce_cyc[b],
                 2 * SLOW_DIV);
      end
    end
    vectors++;
    if (rdv_cnt - r != 1 || rdv_data !== 8'hC3 || rdv_stall !== 1'b0) begin
      errors++;
      $display("FAIL read_data: pulses=%0d data=%h stall=%b, required 1 C3 0",
               rdv_cnt - r, rdv_data, rdv_stall);
    end
  endtask

  task automatic test_io();
    logic st;
    int b = ce_addr.size();
    bus(1'b1, 8'hE1, 16'hC000, 8'h77, 1'b1, st);
    vectors++;
    if (st !== 1'b0) begin errors++; $display("FAIL io_stall: got %b, required 0", st); end
    step(2 * SLOW_DIV);
    vectors++;
    if (ce_addr.size() != b) begin
      errors++;
      $display("FAIL io_access: got %0d slow accesses, required 0", ce_addr.size() - b);
    end
  endtask

  task automatic test_reset_mid();
    logic st;
    int b;
    sync_slot();
    b = ce_addr.size();
    for (int i = 0; i < 3; i++)
      bus(1'b1, 8'h00, 16'h0600 + 16'(i), 8'h90 + 8'(i), 1'b0, st);
    bus(1'b0, 8'hE0, 16'h0400, 8'h00, 1'b0, st);
    vectors++;
    if (st !== 1'b1) begin errors++; $display("FAIL mid_read_stall: got %b, required 1", st); end
    step(2);
    #2 reset_n = 1'b0;
    #1 check_zero("reset_mid");
    step(2);
    reset_n = 1'b1;
    step(3 * SLOW_DIV);
    vectors++;
    if (ce_addr.size() != b || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stale: got %0d slow accesses stall=%b, required 0 0",
               ce_addr.size() - b, cpu_stall);
    end
  endtask

  initial begin
    test_reset();
    test_text();
    test_shr();
    test_back_to_back();
    test_read();
    test_io();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
